axis_ramp_pkt_checker: RTL and testbench

AXIS_RAMP_PKT_CHECKER -- requirements
Module: axis_ramp_pkt_checker

---
 rtl/axis_ramp_pkt_checker.sv | 160 ++++++++++++++++
 tb/tb_axis_ramp_pkt_checker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/axis_ramp_pkt_checker.sv
// AXI-Stream ramp packet checker: compares each packet against a ramp described by
// a length/start/increment latched on the packet's first beat, and keeps statistics.
module axis_ramp_pkt_checker #(
    parameter int DWIDTH = 64,
    parameter int LWIDTH = 16,
    parameter int CWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [LWIDTH-1:0] cfg_len,
    input  logic [DWIDTH-1:0] cfg_start,
    input  logic [DWIDTH-1:0] cfg_inc,
    input  logic              throttle_en,
    input  logic [DWIDTH-1:0] i_tdata,
    input  logic              i_tvalid,
    input  logic              i_tlast,
    output logic              i_tready,
    output logic [CWIDTH-1:0] pkt_count,
    output logic [CWIDTH-1:0] err_count,
    output logic              err_sticky,
    output logic [LWIDTH-1:0] first_err_idx
);
    typedef enum logic [1:0] {IDLE = 2'd0, BODY = 2'd1, DRAIN = 2'd2} state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    state_t              state_r;
    logic [15:0]         lfsr_r;
    logic [DWIDTH-1:0]   exp_r;
    logic [DWIDTH-1:0]   inc_r;
    logic [LWIDTH-1:0]   len_r;
    logic [LWIDTH-1:0]   idx_r;
    logic                pkt_err_r;
    logic [CWIDTH-1:0]   pkt_count_r;
    logic [CWIDTH-1:0]   err_count_r;
    logic                err_sticky_r;
    logic [LWIDTH-1:0]   first_err_idx_r;

    logic                xfer_s;
    logic [LWIDTH-1:0]   cur_len_s;
    logic [LWIDTH-1:0]   cur_idx_s;
    logic [DWIDTH-1:0]   cur_exp_s;
    logic [DWIDTH-1:0]   cur_inc_s;
    logic                prior_err_s;
    logic                last_idx_s;
    logic                checking_s;
    logic                missing_s;
    logic                beat_err_s;
    logic                pkt_err_s;

    assign i_tready      = ~reset & (throttle_en ? lfsr_r[0] : 1'b1);
    assign pkt_count     = pkt_count_r;
    assign err_count     = err_count_r;
    assign err_sticky    = err_sticky_r;
    assign first_err_idx = first_err_idx_r;

    // Per-beat check: in IDLE the live cfg inputs describe beat 0, otherwise the latched copy.
    always_comb begin
        xfer_s = i_tvalid & i_tready;
        if (state_r == IDLE) begin
            cur_len_s   = (cfg_len == {LWIDTH{1'b0}}) ? LWIDTH'(1) : cfg_len;
            cur_idx_s   = {LWIDTH{1'b0}};
            cur_exp_s   = cfg_start;
            cur_inc_s   = cfg_inc;
            prior_err_s = 1'b0;
        end else begin
            cur_len_s   = len_r;
            cur_idx_s   = idx_r;
            cur_exp_s   = exp_r;
            cur_inc_s   = inc_r;
            prior_err_s = pkt_err_r;
        end
        last_idx_s = (cur_idx_s == cur_len_s - LWIDTH'(1));
        checking_s = xfer_s & (state_r != DRAIN);
        missing_s  = checking_s & ~i_tlast & last_idx_s;
        beat_err_s = checking_s & ((i_tdata != cur_exp_s) | (i_tlast & ~last_idx_s) | missing_s);
        pkt_err_s  = prior_err_s | beat_err_s;
    end

    // Packet tracking FSM and backpressure LFSR.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            lfsr_r    <= LFSR_SEED;
            exp_r     <= {DWIDTH{1'b0}};
            inc_r     <= {DWIDTH{1'b0}};
            len_r     <= LWIDTH'(1);
            idx_r     <= {LWIDTH{1'b0}};
            pkt_err_r <= 1'b0;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
            if (xfer_s) begin
                case (state_r)
                    IDLE, BODY: begin
                        len_r     <= cur_len_s;
                        inc_r     <= cur_inc_s;
                        exp_r     <= cur_exp_s + cur_inc_s;
                        idx_r     <= cur_idx_s + LWIDTH'(1);
                        pkt_err_r <= i_tlast ? 1'b0 : pkt_err_s;
                        if (i_tlast) begin
                            state_r <= IDLE;
                        end else if (missing_s) begin
                            state_r <= DRAIN;
                        end else begin
                            state_r <= BODY;
                        end
                    end
                    DRAIN: begin
                        if (i_tlast) begin
                            state_r   <= IDLE;
                            pkt_err_r <= 1'b0;
                        end else begin
                            state_r   <= DRAIN;
                        end
                    end
                    default: begin
                        state_r   <= IDLE;
                        pkt_err_r <= 1'b0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    // Statistics; a clear wins over any event landing in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pkt_count_r     <= {CWIDTH{1'b0}};
            err_count_r     <= {CWIDTH{1'b0}};
            err_sticky_r    <= 1'b0;
            first_err_idx_r <= {LWIDTH{1'b0}};
        end else begin
            if (xfer_s && i_tlast) begin
                pkt_count_r <= pkt_count_r + CWIDTH'(1);
                if (pkt_err_s && (err_count_r != {CWIDTH{1'b1}})) begin
                    err_count_r <= err_count_r + CWIDTH'(1);
                end else begin
                    err_count_r <= err_count_r;
                end
            end else begin
                pkt_count_r <= pkt_count_r;
            end
            if (beat_err_s && !err_sticky_r) begin
                err_sticky_r    <= 1'b1;
                first_err_idx_r <= cur_idx_s;
            end else begin
                err_sticky_r    <= err_sticky_r;
            end
        end
    end

endmodule

// File: tb/tb_axis_ramp_pkt_checker.sv
// Directed bench for axis_ramp_pkt_checker: a packet-level model checked every cycle,
// plus literal expectations after each scenario.
module tb_axis_ramp_pkt_checker;
    logic        clk = 1'b0;
    logic        reset, clear, throttle_en;
    logic [15:0] cfg_len;
    logic [63:0] cfg_start, cfg_inc, i_tdata;
    logic        i_tvalid, i_tlast;
    logic        i_tready;
    logic [31:0] pkt_count, err_count;
    logic        err_sticky;
    logic [15:0] first_err_idx;

    int n_err = 0;
    int n_checks = 0;

    axis_ramp_pkt_checker dut (
        .clk(clk), .reset(reset), .clear(clear), .cfg_len(cfg_len),
        .cfg_start(cfg_start), .cfg_inc(cfg_inc), .throttle_en(throttle_en),
        .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tlast(i_tlast), .i_tready(i_tready),
        .pkt_count(pkt_count), .err_count(err_count), .err_sticky(err_sticky),
        .first_err_idx(first_err_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Packet-level model: expected beat value is start + idx*inc.
    logic [15:0] m_lfsr;
    bit          m_active, m_drain, m_perr, m_sticky;
    int          m_idx, m_len;
    logic [63:0] m_start, m_inc;
    logic [31:0] m_pkt, m_err;
    logic [15:0] m_first;

    initial forever begin
        bit rdy, be, ev_cnt, ev_err, ev_first;
        int ev_idx;
        @(posedge clk);
        if (reset) begin
            m_lfsr = 16'hACE1; m_active = 0; m_drain = 0; m_perr = 0; m_idx = 0;
            m_pkt = 32'd0; m_err = 32'd0; m_sticky = 0; m_first = 16'd0;
        end else begin
            rdy = throttle_en ? m_lfsr[0] : 1'b1;
            ev_cnt = 0; ev_err = 0; ev_first = 0; ev_idx = 0;
            if (i_tvalid && rdy) begin
                if (!m_active) begin
                    m_active = 1; m_drain = 0; m_idx = 0; m_perr = 0;
                    m_len = (cfg_len == 16'd0) ? 1 : int'(cfg_len);
                    m_start = cfg_start; m_inc = cfg_inc;
                end
                be = 0;
                if (!m_drain)
                    be = (i_tdata != m_start + 64'(m_idx) * m_inc) ||
                         (i_tlast && m_idx < m_len - 1) || (!i_tlast && m_idx == m_len - 1);
                if (be) begin
                    m_perr = 1;
                    if (!m_sticky) begin ev_first = 1; ev_idx = m_idx; end
                end
                if (i_tlast) begin
                    ev_cnt = 1; ev_err = m_perr; m_active = 0; m_drain = 0;
                end else if (!m_drain && m_idx == m_len - 1) begin
                    m_drain = 1;
                end
                m_idx++;
            end
            if (clear) begin
                m_pkt = 32'd0; m_err = 32'd0; m_sticky = 0; m_first = 16'd0;
            end else begin
                if (ev_cnt) m_pkt = m_pkt + 32'd1;
                if (ev_cnt && ev_err && m_err != 32'hFFFF_FFFF) m_err = m_err + 32'd1;
                if (ev_first) begin m_sticky = 1; m_first = 16'(ev_idx); end
            end
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        chk("tready", 64'(i_tready), 64'(!reset && (throttle_en ? m_lfsr[0] : 1'b1)));
        chk("pkt_count", 64'(pkt_count), 64'(m_pkt));
        chk("err_count", 64'(err_count), 64'(m_err));
        chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
        chk("first_err_idx", 64'(first_err_idx), 64'(m_first));
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic beat(input logic [63:0] d, input logic l, input logic c);
        bit r = 0;
        int n = 0;
        i_tdata = d; i_tlast = l; i_tvalid = 1'b1; clear = c;
        while (!r && n < 1000) begin
            @(negedge clk); r = i_tready;
            step(); n++;
        end
        if (!r) begin
            n_checks++; n_err++;
            $display("FAIL handshake_timeout: got no ready within %0d cycles", n);
        end
        i_tvalid = 1'b0; i_tlast = 1'b0; clear = 1'b0;
    endtask

    // Sends beats 0..last_at of a ramp; cfg is scrambled after beat 0 to prove it is latched.
    task automatic send_pkt(input logic [15:0] len, input logic [63:0] start, input logic [63:0] inc,
                            input int last_at, input int corrupt, input bit clr_last, input int max_gap);
        logic [63:0] d;
        cfg_len = len; cfg_start = start; cfg_inc = inc;
        for (int i = 0; i <= last_at; i++) begin
            d = start + 64'(i) * inc;
            if (i == corrupt) d = d ^ 64'h1;
            beat(d, i == last_at, clr_last && (i == last_at));
            cfg_start = ~start; cfg_inc = inc + 64'd7; cfg_len = len + 16'd3;
            repeat ($urandom_range(max_gap, 0)) step();
        end
    endtask

    task automatic chk_stats(input string tag, input int p, input int e, input int s, input int f);
        chk({tag, "_pkt"}, 64'(pkt_count), 64'(p));
        chk({tag, "_err"}, 64'(err_count), 64'(e));
        chk({tag, "_sticky"}, 64'(err_sticky), 64'(s));
        chk({tag, "_first"}, 64'(first_err_idx), 64'(f));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] rl;
        reset = 1'b1; clear = 1'b0; throttle_en = 1'b0;
        cfg_len = 16'd8; cfg_start = 64'd0; cfg_inc = 64'd1;
        i_tdata = 64'd0; i_tvalid = 1'b0; i_tlast = 1'b0;
        repeat (3) step();
        chk("reset_tready", 64'(i_tready), 64'd0);
        chk_stats("reset", 0, 0, 0, 0);
        reset = 1'b0;
        step();

        send_pkt(16'd8, 64'd0, 64'd1, 7, -1, 0, 0);
        chk_stats("ramp8", 1, 0, 0, 0);
        send_pkt(16'd4, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 3, -1, 0, 1);
        chk_stats("wrap", 2, 0, 0, 0);
        send_pkt(16'd4, 64'h100, 64'd3, 3, 2, 0, 0);
        chk_stats("corrupt", 3, 1, 1, 2);
        send_pkt(16'd4, 64'h200, 64'd5, 3, -1, 0, 0);
        chk_stats("good_after", 4, 1, 1, 2);
        send_pkt(16'd4, 64'd0, 64'd1, 1, -1, 0, 0);
        chk_stats("early_last", 5, 2, 1, 2);
        send_pkt(16'd4, 64'd0, 64'd1, 5, -1, 0, 0);
        chk_stats("drain", 6, 3, 1, 2);
        send_pkt(16'd0, 64'h55, 64'd9, 0, -1, 0, 0);
        chk_stats("len0", 7, 3, 1, 2);

        clear = 1'b1; step(); clear = 1'b0;
        chk_stats("clear", 0, 0, 0, 0);
        send_pkt(16'd3, 64'h1000, 64'h10, 2, 2, 1, 0);
        chk_stats("clear_on_last", 0, 0, 0, 0);

        cfg_len = 16'd8; cfg_start = 64'h10; cfg_inc = 64'd1;
        for (int i = 0; i < 3; i++) beat(64'h10 + 64'(i), 1'b0, 1'b0);
        reset = 1'b1; step(); step();
        chk("midreset_tready", 64'(i_tready), 64'd0);
        reset = 1'b0;
        send_pkt(16'd8, 64'd0, 64'd1, 7, -1, 0, 0);
        chk_stats("after_reset", 1, 0, 0, 0);

        clear = 1'b1; step(); clear = 1'b0;
        throttle_en = 1'b1;
        for (int p = 0; p < 100; p++) begin
            rl = 16'($urandom_range(12, 0));
            send_pkt(rl, {$urandom, $urandom}, {$urandom, $urandom},
                     (rl == 16'd0) ? 0 : int'(rl) - 1, -1, 0, 2);
        end
        chk_stats("throttle", 100, 0, 0, 0);
        throttle_en = 1'b0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
